cache_controller: RTL and testbench
===================================

# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and `SRAM_Controller`. Read hits complete in the same cycle with no stall. Read misses fetch one word from SRAM and fill a line. All writes go through to SRAM, and a write hit also updates the cached copy. The MEM stage stalls on `ready`, exactly as it did when connected directly to the SRAM controller.

## Interface
- `INDEX_W`, default 6: set-index width, giving 64 sets.
- `TAG_W`, default 10: tag width.
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `read_en`  in  1: MEM-stage load request, held until `ready`.
- `write_en`  in  1: MEM-stage store request, held until `ready`.
- `address`  in  32: byte address; data memory starts at 1024.
- `writeData`  in  32: store data.
- `readData`  out  32: load data, valid while `ready`=1 for a read.
- `ready`  out  1: request completes this cycle; 1 when idle with no request.
- `sram_read_en`  out  1: read request to SRAM_Controller.
- `sram_write_en`  out  1: write request to SRAM_Controller.
- `sram_address`  out  32: equals `address`, passed unchanged.
- `sram_writeData`  out  32: equals `writeData`.
- `sram_readData`  in  32: SRAM read data.
- `sram_ready`  in  1: SRAM_Controller done pulse.

## Operation
- Address decode:
  - waddr = (address − 1024) >> 2;
  - index = waddr[INDEX_W−1:0];
  - tag = waddr[INDEX_W+TAG_W−1:INDEX_W].
- Per set, each of way0 and way1 holds valid, tag[TAG_W] and data[32]. Each set also holds one `lru` bit, equal to the way number of the least-recently-used way.
- Hit on way w: valid_w=1 and tag_w=tag.
- FSM states: IDLE, RMISS, WRITE.
- IDLE:
  - read_en and hit: `ready`=1 and `readData`=data of the hit way, combinationally. Next edge: lru[index] ← ~w. Stay in IDLE.
  - read_en and miss: `ready`=0. Next state RMISS.
  - write_en (and read_en=0): `ready`=0. Next state WRITE.
  - read_en has priority if both read_en and write_en are high.
  - Neither request: `ready`=1, no state change.
- RMISS:
  - `sram_read_en`=1 and `ready`=0 until `sram_ready`=1.
  - On the `sram_ready` cycle: `ready`=1 and `readData`=`sram_readData`, combinationally.
  - At the edge that ends the `sram_ready` cycle:
    - Choose the victim: way0 if invalid, else way1 if invalid, else lru[index].
    - Write the victim: valid ← 1, tag ← tag, data ← `sram_readData`.
    - Update lru[index] ← ~victim.
    - Next state IDLE.
- WRITE:
  - `sram_write_en`=1 and `ready`=0 until `sram_ready`=1.
  - On the `sram_ready` cycle: `ready`=1.
  - At the edge that ends the `sram_ready` cycle: on a hit on way w, data_w ← `writeData` and lru[index] ← ~w. On a miss, the cache is unchanged.
  - Next state IDLE.
- `sram_ready` is ignored in IDLE, because SRAM_Controller drives it high when idle.
- `sram_read_en` and `sram_write_en` are never high together.
- `sram_read_en` and `sram_write_en` are low in IDLE.

## Timing
- Reset (`rst`=0, asynchronous):
  - state ← IDLE;
  - all valid bits ← 0;
  - all lru bits ← 0.
- Outputs during and after reset with no request:
  - `ready`=1;
  - `sram_read_en`=0, `sram_write_en`=0;
  - `readData`=0.
- Tag and data arrays need no reset.
- Reset asserted mid-RMISS or mid-WRITE: the transaction is aborted, no line is filled, and the SRAM strobes drop immediately.
- Latency:
  - read hit: 0 stall cycles;
  - read miss or any write: 1 + N stall cycles, where N is the number of cycles until `sram_ready`. `ready` goes high in the `sram_ready` cycle.
- The requester deasserts or changes its request on the edge after `ready`=1. The block does not track that completed request and treats whatever arrives next in IDLE as a new request.
- Back-to-back hits: one completes per cycle.
- A fill and an immediate re-read of the same address: the re-read hits in the cycle right after the fill edge.
- A write hit updates the array only at completion, so a read issued after the write's `ready` returns the new data.

## Test plan
- Reset, then read 0x400 (cold): `sram_read_en` held until `sram_ready`. `ready`=1 with `readData`=SRAM word. A repeat read of 0x400 hits with 0 stall cycles.
- Reads of 0x400, 0x500 and 0x600, which all map to index 0:
  - 0x400 and 0x500 fill way0 and way1.
  - Re-read 0x400, so lru points to way1.
  - 0x600 evicts 0x500.
  - Re-read 0x400 hits; re-read 0x500 misses.
- Write 0x12345678 to cached 0x404: `sram_write_en` held until `sram_ready`. A following read of 0x404 hits and returns 0x12345678 with no SRAM access.
- Write to uncached 0x800: SRAM write occurs. A following read of 0x800 misses, confirming no allocate.
- `read_en` and `write_en` both 1 in IDLE: only `sram_read_en` is asserted and the read path is taken.
- Assert `rst` low during RMISS: state is IDLE immediately, `sram_read_en`=0 and `ready`=1. A subsequent read of the same address misses.

Source files
------------

// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the data cache and SRAM_Controller.
// The slave view belongs to the cache; the master view belongs to the
// environment that drives the MEM-side requests and the SRAM responses.
interface cache_controller_if;
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_address;
  logic [31:0] sram_writeData;
  logic [31:0] sram_readData;
  logic        sram_ready;

  modport slave (
    input  read_en, write_en, address, writeData, sram_readData, sram_ready,
    output readData, ready, sram_read_en, sram_write_en, sram_address,
           sram_writeData
  );

  modport master (
    output read_en, write_en, address, writeData, sram_readData, sram_ready,
    input  readData, ready, sram_read_en, sram_write_en, sram_address,
           sram_writeData
  );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Read hits answer combinationally; read misses fetch one word and fill a
// line; every write goes to SRAM and refreshes the cached copy on a hit.
module cache_controller #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);
  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0] valid0_q, valid0_d;
  logic [SETS-1:0] valid1_q, valid1_d;
  logic [SETS-1:0] lru_q, lru_d;

  // Tag and data storage carry no reset; valid bits qualify them.
  logic [TAG_W-1:0] tag0_q  [SETS];
  logic [TAG_W-1:0] tag1_q  [SETS];
  logic [31:0]      data0_q [SETS];
  logic [31:0]      data1_q [SETS];

  logic [31:0]                   offset;
  logic [31-INDEX_W-TAG_W-2:0]   unused_hi;
  logic [1:0]                    unused_lo;
  logic [INDEX_W-1:0]            req_idx;
  logic [TAG_W-1:0]              req_tag;

  logic        hit0, hit1, hit;
  logic        victim;
  logic        way0_we, way1_we;
  logic [31:0] line_wdata;

  // Word address relative to the start of data memory, split into tag/index.
  assign offset = bus.address - 32'd1024;
  assign {unused_hi, req_tag, req_idx, unused_lo} = offset;

  assign hit0 = valid0_q[req_idx] && (tag0_q[req_idx] == req_tag);
  assign hit1 = valid1_q[req_idx] && (tag1_q[req_idx] == req_tag);
  assign hit  = hit0 || hit1;

  assign bus.sram_address   = bus.address;
  assign bus.sram_writeData = bus.writeData;

  // State, valid and LRU registers; reset invalidates every line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
    end
  end

  // Line storage: written on a miss fill or on a write hit.
  always_ff @(posedge clk) begin
    if (way0_we) begin
      tag0_q[req_idx]  <= req_tag;
      data0_q[req_idx] <= line_wdata;
    end
    if (way1_we) begin
      tag1_q[req_idx]  <= req_tag;
      data1_q[req_idx] <= line_wdata;
    end
  end

  // Next-state, array update controls and handshake outputs.
  always_comb begin
    state_d           = state_q;
    valid0_d          = valid0_q;
    valid1_d          = valid1_q;
    lru_d             = lru_q;
    victim            = 1'b0;
    way0_we           = 1'b0;
    way1_we           = 1'b0;
    line_wdata        = '0;
    bus.ready         = 1'b1;
    bus.readData      = '0;
    bus.sram_read_en  = 1'b0;
    bus.sram_write_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.read_en) begin
          if (hit) begin
            bus.readData   = hit0 ? data0_q[req_idx] : data1_q[req_idx];
            lru_d[req_idx] = hit0;
          end else begin
            bus.ready = 1'b0;
            state_d   = RMISS;
          end
        end else if (bus.write_en) begin
          bus.ready = 1'b0;
          state_d   = WRITE;
        end
      end
      RMISS: begin
        bus.sram_read_en = 1'b1;
        bus.ready        = 1'b0;
        if (bus.sram_ready) begin
          bus.ready    = 1'b1;
          bus.readData = bus.sram_readData;
          if (!valid0_q[req_idx])      victim = 1'b0;
          else if (!valid1_q[req_idx]) victim = 1'b1;
          else                         victim = lru_q[req_idx];
          line_wdata = bus.sram_readData;
          if (victim) begin
            way1_we           = 1'b1;
            valid1_d[req_idx] = 1'b1;
          end else begin
            way0_we           = 1'b1;
            valid0_d[req_idx] = 1'b1;
          end
          lru_d[req_idx] = ~victim;
          state_d        = IDLE;
        end
      end
      WRITE: begin
        bus.sram_write_en = 1'b1;
        bus.ready         = 1'b0;
        if (bus.sram_ready) begin
          bus.ready  = 1'b1;
          line_wdata = bus.writeData;
          if (hit) begin
            way0_we        = hit0;
            way1_we        = !hit0;
            lru_d[req_idx] = hit0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is held the block presents an idle, ready port.
    if (!rst) begin
      bus.ready         = 1'b1;
      bus.readData      = '0;
      bus.sram_read_en  = 1'b0;
      bus.sram_write_en = 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, a reset-during-miss
// sequence, and random traffic against a timestamp-based reference cache.
module tb_cache_controller;
  localparam int SETS = 64;

  logic clk;
  logic rst;
  cache_controller_if bus();

  cache_controller #(.INDEX_W(6), .TAG_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SRAM contents seen by the DUT, and the reference model's own copy.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Reference cache: per way valid/tag/data plus a last-use timestamp.
  bit          mv [2][SETS];
  int          mt [2][SETS];
  logic [31:0] md [2][SETS];
  longint      ms [2][SETS];
  longint      now;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    int          exp_stall;
    logic [31:0] exp_data;
    bit          exp_srd;
    bit          exp_swr;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hD000, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < SETS; s++) begin
        mv[w][s] = 1'b0;
        ms[w][s] = 0;
      end
    now = 0;
  endtask

  task automatic model_access(input bit rd, input logic [31:0] a,
                              input logic [31:0] wd, output bit hit,
                              output logic [31:0] data);
    int w, s, t, way;
    w = int'((a - 32'd1024) / 4);
    s = w % SETS;
    t = (w / SETS) % 1024;
    now++;
    hit = 1'b0;
    way = 0;
    data = '0;
    for (int i = 0; i < 2; i++)
      if (!hit && mv[i][s] && mt[i][s] == t) begin
        hit = 1'b1;
        way = i;
      end
    if (rd) begin
      if (hit) data = md[way][s];
      else begin
        data = ref_rd(a);
        if (!mv[0][s])      way = 0;
        else if (!mv[1][s]) way = 1;
        else                way = (ms[0][s] < ms[1][s]) ? 0 : 1;
        mv[way][s] = 1'b1;
        mt[way][s] = t;
        md[way][s] = data;
      end
      ms[way][s] = now;
    end else begin
      ref_mem[a] = wd;
      if (hit) begin
        md[way][s] = wd;
        ms[way][s] = now;
      end
    end
  endtask

  // Present one request and play SRAM_Controller until ready is seen.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int lat,
                         output int stalls, output logic [31:0] rdata,
                         output bit saw_rd, output bit saw_wr);
    int k;
    bit done;
    bus.read_en   = rd;
    bus.write_en  = wr;
    bus.address   = a;
    bus.writeData = wd;
    stalls = 0;
    rdata  = '0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    k      = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (bus.sram_read_en || bus.sram_write_en) begin
        k++;
        if (bus.sram_read_en)  saw_rd = 1'b1;
        if (bus.sram_write_en) saw_wr = 1'b1;
        check("strobe_excl", 32'(bus.sram_read_en && bus.sram_write_en), 32'd0);
        check("sram_address", bus.sram_address, a);
        if (k > lat) begin
          bus.sram_ready    = 1'b1;
          bus.sram_readData = mem_rd(a);
        end else begin
          bus.sram_ready    = 1'b0;
          bus.sram_readData = 32'hDEAD_BEEF ^ 32'(k);
        end
      end else begin
        bus.sram_ready = 1'b1;
      end
      #1;
      if (bus.ready) begin
        done  = 1'b1;
        rdata = bus.readData;
        if (bus.sram_write_en && bus.sram_ready) mem[a] = bus.sram_writeData;
      end else begin
        stalls++;
      end
    end
    if (!done) check("txn_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.read_en    = 1'b0;
    bus.write_en   = 1'b0;
    bus.sram_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.read_en   = 1'b0;
    bus.write_en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    int          stalls;
    logic [31:0] rdata;
    bit          srd, swr, hit;
    logic [31:0] exp_data;
    int          exp_stall;

    tbl[0]  = '{1, 0, 32'h400, 32'h0,        2, 3, 32'hD0000400, 1, 0};
    tbl[1]  = '{1, 0, 32'h400, 32'h0,        0, 0, 32'hD0000400, 0, 0};
    tbl[2]  = '{1, 0, 32'h500, 32'h0,        1, 2, 32'hD0000500, 1, 0};
    tbl[3]  = '{1, 0, 32'h400, 32'h0,        0, 0, 32'hD0000400, 0, 0};
    tbl[4]  = '{1, 0, 32'h600, 32'h0,        0, 1, 32'hD0000600, 1, 0};
    tbl[5]  = '{1, 0, 32'h400, 32'h0,        0, 0, 32'hD0000400, 0, 0};
    tbl[6]  = '{1, 0, 32'h500, 32'h0,        3, 4, 32'hD0000500, 1, 0};
    tbl[7]  = '{1, 0, 32'h404, 32'h0,        0, 1, 32'hD0000404, 1, 0};
    tbl[8]  = '{0, 1, 32'h404, 32'h12345678, 2, 3, 32'h0,        0, 1};
    tbl[9]  = '{1, 0, 32'h404, 32'h0,        0, 0, 32'h12345678, 0, 0};
    tbl[10] = '{0, 1, 32'h800, 32'hCAFEF00D, 1, 2, 32'h0,        0, 1};
    tbl[11] = '{1, 0, 32'h800, 32'h0,        0, 1, 32'hCAFEF00D, 1, 0};
    tbl[12] = '{1, 1, 32'h900, 32'h11111111, 1, 2, 32'hD0000900, 1, 0};
    tbl[13] = '{1, 0, 32'h900, 32'h0,        0, 0, 32'hD0000900, 0, 0};
    tbl[14] = '{1, 0, 32'h600, 32'h0,        0, 1, 32'hD0000600, 1, 0};

    rst               = 1'b0;
    bus.read_en       = 1'b0;
    bus.write_en      = 1'b0;
    bus.address       = 32'h400;
    bus.writeData     = '0;
    bus.sram_ready    = 1'b1;
    bus.sram_readData = '0;

    #3;
    check("rst_ready",    32'(bus.ready),         32'd1);
    check("rst_sram_rd",  32'(bus.sram_read_en),  32'd0);
    check("rst_sram_wr",  32'(bus.sram_write_en), 32'd0);
    check("rst_readData", bus.readData,           32'd0);
    do_reset();
    check("idle_ready",    32'(bus.ready),        32'd1);
    check("idle_readData", bus.readData,          32'd0);

    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat,
              stalls, rdata, srd, swr);
      check($sformatf("vec%0d_stall", i), 32'(stalls), 32'(tbl[i].exp_stall));
      check($sformatf("vec%0d_sram_rd", i), 32'(srd), 32'(tbl[i].exp_srd));
      check($sformatf("vec%0d_sram_wr", i), 32'(swr), 32'(tbl[i].exp_swr));
      if (tbl[i].rd)
        check($sformatf("vec%0d_data", i), rdata, tbl[i].exp_data);
    end

    // Reset in the middle of a read miss aborts the fill.
    bus.read_en = 1'b1;
    bus.address = 32'h440;
    @(negedge clk);
    bus.sram_ready = 1'b1;
    @(negedge clk);
    check("abort_in_rmiss", 32'(bus.sram_read_en), 32'd1);
    bus.sram_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("abort_sram_rd",  32'(bus.sram_read_en), 32'd0);
    check("abort_ready",    32'(bus.ready),        32'd1);
    check("abort_readData", bus.readData,          32'd0);
    @(negedge clk);
    rst            = 1'b1;
    bus.read_en    = 1'b0;
    bus.sram_ready = 1'b1;
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 32'h440, 32'h0, 1, stalls, rdata, srd, swr);
    check("abort_reread_stall", 32'(stalls), 32'd2);
    check("abort_reread_data",  rdata,       32'hD0000440);

    // Random traffic on a small address pool against the reference model.
    do_reset();
    mem.delete();
    ref_mem.delete();
    for (int n = 0; n < 300; n++) begin
      bit          rd, wr;
      logic [31:0] a, wd;
      int          lat;
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      a   = 32'd1024 + 32'(4 * ($urandom_range(0, 3) * SETS + $urandom_range(0, 3)));
      wd  = $urandom;
      lat = $urandom_range(0, 3);
      model_access(rd, a, wd, hit, exp_data);
      exp_stall = (rd && hit) ? 0 : 1 + lat;
      run_txn(rd, wr, a, wd, lat, stalls, rdata, srd, swr);
      check($sformatf("rnd%0d_stall", n), 32'(stalls), 32'(exp_stall));
      check($sformatf("rnd%0d_sram_rd", n), 32'(srd), 32'(rd && !hit));
      check($sformatf("rnd%0d_sram_wr", n), 32'(swr), 32'(!rd));
      if (rd) check($sformatf("rnd%0d_data", n), rdata, exp_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
